// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit.
package mem_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 10;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/dmem_ram.sv
// Data RAM: asynchronous clear, byte-enabled synchronous write, asynchronous read.
module dmem_ram
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        wbe,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_W;

  logic [31:0] mem [DEPTH];

  // wbe[3] is the most significant (big-endian offset 0) lane
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (wbe[b]) begin
          mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MEM-stage lane logic: big-endian byte/half/word access, extension and alignment check.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_busB,
  input  logic        mem_MemWr,
  input  logic        mem_MemRead,
  input  logic [1:0]  mem_MemSize,
  input  logic        mem_MemSigned,
  output logic [31:0] mem_dout,
  output logic        mem_addr_err
);

  logic [ADDR_W-1:0] word_addr;
  logic [1:0]        offset;
  logic              is_byte;
  logic              is_half;
  logic              is_word;
  logic              misaligned;
  logic [3:0]        wbe;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       load_val;
  logic              unused_addr_hi;

  // Upper address bits are dropped so accesses wrap around the RAM
  assign word_addr      = mem_alu_result[ADDR_W+1:2];
  assign offset         = mem_alu_result[1:0];
  assign unused_addr_hi = ^mem_alu_result[31:ADDR_W+2];

  assign is_byte = (mem_MemSize == SZ_BYTE);
  assign is_half = (mem_MemSize == SZ_HALF);
  assign is_word = mem_MemSize[1];

  assign misaligned = (is_half & offset[0]) | (is_word & (offset != 2'b00));

  // Byte-enable mask and lane-replicated store data
  always_comb begin
    wbe   = 4'b0000;
    wdata = mem_busB;
    if (is_byte) begin
      wbe   = 4'b1000 >> offset;
      wdata = {4{mem_busB[7:0]}};
    end else if (is_half) begin
      wbe   = offset[1] ? 4'b0011 : 4'b1100;
      wdata = {2{mem_busB[15:0]}};
    end else begin
      wbe   = 4'b1111;
    end
    if (!mem_MemWr || misaligned) begin
      wbe = 4'b0000;
    end
  end

  dmem_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .Clk   (Clk),
    .Reset (Reset),
    .addr  (word_addr),
    .wbe   (wbe),
    .wdata (wdata),
    .rdata (rdata)
  );

  // Lane extraction and sign/zero extension
  always_comb begin
    rd_byte  = 8'h00;
    rd_half  = offset[1] ? rdata[15:0] : rdata[31:16];
    load_val = rdata;
    case (offset)
      2'd0:    rd_byte = rdata[31:24];
      2'd1:    rd_byte = rdata[23:16];
      2'd2:    rd_byte = rdata[15:8];
      default: rd_byte = rdata[7:0];
    endcase
    if (is_byte) begin
      load_val = {{24{mem_MemSigned & rd_byte[7]}}, rd_byte};
    end else if (is_half) begin
      load_val = {{16{mem_MemSigned & rd_half[15]}}, rd_half};
    end
  end

  assign mem_dout     = (mem_MemRead && !misaligned && !Reset) ? load_val : 32'h0;
  assign mem_addr_err = (mem_MemRead | mem_MemWr) & misaligned & ~Reset;

endmodule

// File: tb/tb_mem_stage.sv
// Directed scoreboard bench for mem_stage: loads, stores, alignment, wrap and reset.
module tb_mem_stage;
  import mem_pkg::*;

  typedef struct {
    string       tag;
    logic [31:0] dout;
    logic        err;
  } exp_t;

  logic        Clk;
  logic        Reset;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_busB;
  logic        mem_MemWr;
  logic        mem_MemRead;
  logic [1:0]  mem_MemSize;
  logic        mem_MemSigned;
  logic [31:0] mem_dout;
  logic        mem_addr_err;

  exp_t sb_q[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;

  mem_stage dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .mem_alu_result (mem_alu_result),
    .mem_busB       (mem_busB),
    .mem_MemWr      (mem_MemWr),
    .mem_MemRead    (mem_MemRead),
    .mem_MemSize    (mem_MemSize),
    .mem_MemSigned  (mem_MemSigned),
    .mem_dout       (mem_dout),
    .mem_addr_err   (mem_addr_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic drive(input logic [31:0] addr, input logic [31:0] data,
                       input logic wr, input logic rd,
                       input logic [1:0] size, input logic sgn);
    mem_alu_result = addr;
    mem_busB       = data;
    mem_MemWr      = wr;
    mem_MemRead    = rd;
    mem_MemSize    = size;
    mem_MemSigned  = sgn;
  endtask

  task automatic push(input string tag, input logic [31:0] dout, input logic err);
    exp_t e;
    e.tag  = tag;
    e.dout = dout;
    e.err  = err;
    sb_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    n_compared++;
    assert (sb_q.size() != 0)
    else begin
      n_mismatched++;
      $error("FAIL scoreboard_empty: observed dout=%h err=%b required an entry", mem_dout, mem_addr_err);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      assert (mem_dout === e.dout)
      else begin
        n_mismatched++;
        $error("FAIL %s dout: observed %h expected %h", e.tag, mem_dout, e.dout);
      end
      n_compared++;
      assert (mem_addr_err === e.err)
      else begin
        n_mismatched++;
        $error("FAIL %s err: observed %b expected %b", e.tag, mem_addr_err, e.err);
      end
    end
  endtask

  // One access per cycle: drive after negedge, check before the write edge
  task automatic step(input string tag, input logic [31:0] addr, input logic [31:0] data,
                      input logic wr, input logic rd, input logic [1:0] size,
                      input logic sgn, input logic [31:0] exp_dout, input logic exp_err);
    @(negedge Clk);
    drive(addr, data, wr, rd, size, sgn);
    push(tag, exp_dout, exp_err);
    #1;
    pop_check();
  endtask

  initial begin
    Reset = 1'b1;
    drive(32'h0, 32'h0, 1'b0, 1'b0, SZ_WORD, 1'b0);

    step("reset_read", 32'h10, 32'h0, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h0, 1'b0);
    #2 Reset = 1'b0;

    // Word round-trip
    step("sw_10",  32'h10, 32'hDEADBEEF, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0, 1'b0);
    step("lw_10",  32'h10, 32'h0,        1'b0, 1'b1, SZ_WORD, 1'b0, 32'hDEADBEEF, 1'b0);

    // Byte and halfword stores into a word
    step("sw_20",  32'h20, 32'h11223344, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0, 1'b0);
    step("sb_21",  32'h21, 32'hFFFFFFAB, 1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h0, 1'b0);
    step("lw_20a", 32'h20, 32'h0,        1'b0, 1'b1, SZ_WORD, 1'b0, 32'h11AB3344, 1'b0);
    step("sh_22",  32'h22, 32'hFFFF1234, 1'b1, 1'b0, SZ_HALF, 1'b1, 32'h0, 1'b0);
    step("lw_20b", 32'h20, 32'h0,        1'b0, 1'b1, SZ_WORD, 1'b0, 32'h11AB1234, 1'b0);

    // Extension
    step("sw_30",  32'h30, 32'h80FF7F01, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0, 1'b0);
    step("lb_30",  32'h30, 32'h0, 1'b0, 1'b1, SZ_BYTE, 1'b1, 32'hFFFFFF80, 1'b0);
    step("lbu_30", 32'h30, 32'h0, 1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h00000080, 1'b0);
    step("lb_31",  32'h31, 32'h0, 1'b0, 1'b1, SZ_BYTE, 1'b1, 32'hFFFFFFFF, 1'b0);
    step("lb_32",  32'h32, 32'h0, 1'b0, 1'b1, SZ_BYTE, 1'b1, 32'h0000007F, 1'b0);
    step("lbu_33", 32'h33, 32'h0, 1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h00000001, 1'b0);
    step("lh_32",  32'h32, 32'h0, 1'b0, 1'b1, SZ_HALF, 1'b1, 32'h00007F01, 1'b0);
    step("lh_30",  32'h30, 32'h0, 1'b0, 1'b1, SZ_HALF, 1'b1, 32'hFFFF80FF, 1'b0);
    step("lhu_30", 32'h30, 32'h0, 1'b0, 1'b1, SZ_HALF, 1'b0, 32'h000080FF, 1'b0);
    step("lw_sgn", 32'h30, 32'h0, 1'b0, 1'b1, SZ_WORD, 1'b1, 32'h80FF7F01, 1'b0);

    // Misalignment
    step("lw_31",  32'h31, 32'h0,    1'b0, 1'b1, SZ_WORD, 1'b0, 32'h0, 1'b1);
    step("lh_31",  32'h31, 32'h0,    1'b0, 1'b1, SZ_HALF, 1'b1, 32'h0, 1'b1);
    step("sh_33",  32'h33, 32'hBEEF, 1'b1, 1'b0, SZ_HALF, 1'b0, 32'h0, 1'b1);
    step("sw_32",  32'h32, 32'h0,    1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0, 1'b1);
    step("lw_30u", 32'h30, 32'h0,    1'b0, 1'b1, SZ_WORD, 1'b0, 32'h80FF7F01, 1'b0);

    // Same-cycle read and write shows old data, new data next cycle
    step("rw_10",  32'h10, 32'h5, 1'b1, 1'b1, SZ_WORD, 1'b0, 32'hDEADBEEF, 1'b0);
    step("lw_10n", 32'h10, 32'h0, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h00000005, 1'b0);

    // Address wrap-around and reserved size
    step("sw_1000", 32'h1000, 32'hCAFEF00D, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0, 1'b0);
    step("lw_0",    32'h0,    32'h0, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'hCAFEF00D, 1'b0);
    step("lw_rsv",  32'h0,    32'h0, 1'b0, 1'b1, 2'b11,   1'b1, 32'hCAFEF00D, 1'b0);
    step("lw_rsv2", 32'h2,    32'h0, 1'b0, 1'b1, 2'b11,   1'b0, 32'h0, 1'b1);
    step("rd_off",  32'h0,    32'h0, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 1'b0);

    // Reset asserted mid-cycle while a store is pending
    @(negedge Clk);
    drive(32'h40, 32'h12345678, 1'b1, 1'b0, SZ_WORD, 1'b0);
    #1 Reset = 1'b1;
    #1;
    push("rst_pending", 32'h0, 1'b0);
    pop_check();
    drive(32'h41, 32'h12345678, 1'b1, 1'b1, SZ_WORD, 1'b0);
    #1;
    push("rst_misalign", 32'h0, 1'b0);
    pop_check();
    drive(32'h40, 32'h12345678, 1'b1, 1'b0, SZ_WORD, 1'b0);
    @(posedge Clk);
    #2 Reset = 1'b0;

    step("lw_40",  32'h40, 32'h0, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h0, 1'b0);
    step("lw_20c", 32'h20, 32'h0, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h0, 1'b0);
    step("lw_10c", 32'h10, 32'h0, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h0, 1'b0);

    // Writes work again after reset
    step("sw_40",  32'h40, 32'hA5A5A5A5, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0, 1'b0);
    step("lb_43",  32'h43, 32'h0, 1'b0, 1'b1, SZ_BYTE, 1'b1, 32'hFFFFFFA5, 1'b0);

    n_compared++;
    assert (sb_q.size() == 0)
    else begin
      n_mismatched++;
      $error("FAIL scoreboard_drain: observed %0d leftover entries expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
MEM-stage data-memory access unit for the 5-stage MIPS pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register. It performs word, halfword and byte loads and stores against an internal data RAM, with big-endian lane selection, sign or zero extension, and alignment checking. Its mem_dout output feeds the MEM/WB register directly, which captures it at the next Clk edge.

Parameters:
ADDR_W, 10, word-address width; the RAM holds 2**ADDR_W 32-bit words.

Ports:
Clk  input  1  pipeline clock; the RAM is written on the rising edge.
Reset  input  1  asynchronous, active-high reset; clears the RAM contents.
mem_alu_result  input  32  byte address computed by the ALU.
mem_busB  input  32  store data, i.e. the rt value after forwarding.
mem_MemWr  input  1  store enable.
mem_MemRead  input  1  load enable.
mem_MemSize  input  2  access size: 00 byte, 01 halfword, 10 word; 11 is reserved and treated as a word.
mem_MemSigned  input  1  for loads: 1 sign-extends, 0 zero-extends; ignored for word accesses.
mem_dout  output  32  load result, already extended.
mem_addr_err  output  1  misaligned-access flag.

Behaviour:
- Reset:
  - While Reset is high, all RAM words are 0 and all writes are blocked.
  - Reset clears the RAM asynchronously, and this takes effect mid-cycle.
  - mem_dout and mem_addr_err are combinational and therefore read 0 during reset whenever the RAM is cleared.
- Address decode:
  - word index = mem_alu_result[ADDR_W+1:2].
  - Bits above that field are ignored, so addresses wrap modulo 4*2**ADDR_W bytes.
  - Byte offset = mem_alu_result[1:0].
- Byte lanes are big-endian:
  - offset 0 selects bits [31:24], 1 selects [23:16], 2 selects [15:8], 3 selects [7:0].
  - Halfword offset 0 selects [31:16]; offset 2 selects [15:0].
- Alignment:
  - mem_addr_err = (MemRead | MemWr) & ((halfword & offset[0]) | (word & offset != 0)).
  - When the flag is set, the store is suppressed and mem_dout = 0.
  - Byte accesses are never misaligned.
- Load path is combinational, with zero latency within the MEM cycle:
  - mem_dout = the selected lanes, extended per mem_MemSigned.
  - mem_dout = 0 when mem_MemRead = 0.
- Store path is synchronous:
  - At posedge Clk, with mem_MemWr = 1, no error and no Reset, the selected lanes are updated.
  - Data comes from the low bits of mem_busB: [7:0] for a byte store, [15:0] for a halfword store, [31:0] for a word store.
  - The other lanes are preserved (read-modify-write with a byte-enable mask).
- Simultaneous read and write of the same word in one cycle: mem_dout shows the pre-write contents. The new value is visible from the following cycle.
- MemRead and MemWr both high is an illegal control combination. The store still occurs, and mem_dout reflects the old data.
- No stall or handshake is needed: every access completes in one cycle.

Decomposition:
- Shared package mem_pkg contains:
  - size encodings SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10;
  - the default ADDR_W.
- Sub-module dmem_ram holds the storage: asynchronous clear, synchronous write with a 4-bit byte-enable, and an asynchronous read port.
- mem_stage holds only the lane logic: enable/mask generation, extraction and extension, and alignment checking.

Test Plan:
1. Word round-trip. Write sw 0xDEADBEEF to address 0x10; next cycle read lw 0x10 -> mem_dout = 0xDEADBEEF, mem_addr_err = 0.
2. Byte store into a word. Start with 0x11223344 at 0x20 (written by sw); sb 0xAB to 0x21; then lw 0x20 -> 0x11AB3344.
3. Byte and halfword extension on 0x80FF7F01 at 0x30:
   - lb 0x30 -> 0xFFFFFF80;
   - lbu 0x30 -> 0x00000080;
   - lh 0x32 -> 0x00007F01;
   - lh 0x30 -> 0xFFFF80FF.
4. Misaligned accesses:
   - lw 0x31 -> mem_addr_err = 1, mem_dout = 0;
   - sh 0x33 with data 0xBEEF -> err = 1, and a following lw 0x30 is unchanged.
5. Same-cycle read/write and wrap-around:
   - With sw 0x5 and lw to the same address in one cycle, mem_dout shows the old value; the next cycle shows 0x5.
   - With ADDR_W = 10, sw to 0x1000 aliases address 0x0.
6. Reset mid-operation. Assert Reset asynchronously between edges while sw 0x12345678 to 0x40 is pending; deassert -> lw 0x40 = 0, and no write occurred during reset.
